// File: rtl/seg_sched_pkg.sv
// Shared types for the segment-frame scheduler: FSM state encoding,
// default frame width and the arbiter grant index type.
package seg_sched_pkg;

  localparam int FRAME_W_DEF = 64;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  // Index of a producer port (0 = display, 1 = overlay).
  typedef logic grant_idx_t;

endpackage

// File: rtl/seg_rr_arb2.sv
// Two-way round-robin arbiter: one-hot grant from req, priority pointer
// moves to the losing side whenever a grant is consumed (advance).
module seg_rr_arb2
  import seg_sched_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  grant_idx_t ptr;

  // NOTE: assign a default first in every combinational block so no path
  // leaves the output unassigned; otherwise synthesis infers a latch.
  always_comb begin
    grant = req;
    if (req == 2'b11) begin
      grant = (ptr == 1'b1) ? 2'b10 : 2'b01;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement or block order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr <= 1'b0;
    end else if (advance && (grant != 2'b00)) begin
      // Winner 0 hands priority to 1 and vice versa.
      ptr <= grant[0];
    end
  end

endmodule

// File: rtl/seg_frame_sched.sv
// Round-robin scheduler sharing one 64-bit segment serializer between two
// frame producers. Optional periodic re-send under macro SEG_REFRESH_EN.
module seg_frame_sched
  import seg_sched_pkg::*;
#(
  parameter int FRAME_W        = FRAME_W_DEF,
  parameter int TIMEOUT_CYCLES = 256,
  parameter int REFRESH_CYCLES = 1_000_000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req0,
  input  logic [FRAME_W-1:0] data0,
  output logic               ack0,
  input  logic               req1,
  input  logic [FRAME_W-1:0] data1,
  output logic               ack1,
  output logic [FRAME_W-1:0] seg_data,
  output logic               seg_start,
  input  logic               seg_finish,
  output logic               busy,
  output logic               done,
  output logic               timeout_err
);

  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  if (TIMEOUT_CYCLES < FRAME_W + 4) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must cover a full frame shift");
  end
  if (REFRESH_CYCLES < 1) begin : g_bad_refresh
    $error("REFRESH_CYCLES must be at least 1");
  end

  state_t           state, state_nxt;
  logic [1:0]       grant;
  logic             grant_ok, refresh_fire, in_wait, tmo_hit;
  logic             ack0_nxt, ack1_nxt, seg_start_nxt, done_nxt, tmo_set;
  logic [TMO_W-1:0] tmo_cnt;

  assign in_wait  = (state == WAIT_BUSY) || (state == WAIT_DONE);
  assign tmo_hit  = in_wait && (tmo_cnt == TMO_LAST);
  assign grant_ok = (state == IDLE) && seg_finish && (req0 || req1);
  assign busy     = (state != IDLE);

  seg_rr_arb2 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     ({req1, req0}),
    .advance (grant_ok),
    .grant   (grant)
  );

`ifdef SEG_REFRESH_EN
  localparam int IDLE_W = $clog2(REFRESH_CYCLES + 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(REFRESH_CYCLES);

  logic [IDLE_W-1:0] idle_cnt;

  // Counts quiet idle cycles; saturates so a busy serializer defers the re-send.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idle_cnt <= '0;
    end else if ((state != IDLE) || req0 || req1) begin
      idle_cnt <= '0;
    end else if (idle_cnt != IDLE_LAST) begin
      idle_cnt <= idle_cnt + IDLE_W'(1);
    end
  end

  assign refresh_fire = (state == IDLE) && !req0 && !req1 && seg_finish &&
                        (idle_cnt == IDLE_LAST);
`else
  assign refresh_fire = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:      if (grant_ok || refresh_fire) state_nxt = START;
      START:     state_nxt = WAIT_BUSY;
      WAIT_BUSY: begin
        if (tmo_hit)          state_nxt = IDLE;
        else if (!seg_finish) state_nxt = WAIT_DONE;
      end
      WAIT_DONE: if (seg_finish || tmo_hit) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ack0_nxt      = grant_ok && grant[0];
    ack1_nxt      = grant_ok && grant[1];
    seg_start_nxt = (state == START);
    done_nxt      = (state == WAIT_DONE) && seg_finish;
    // Completion seen on the last allowed cycle still counts as success.
    tmo_set       = tmo_hit && !done_nxt;
  end

  // NOTE: seg_data is a single datapath register, not a memory; it is reset
  // because a defined all-zero frame must reach the serializer after reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ack0        <= 1'b0;
      ack1        <= 1'b0;
      seg_start   <= 1'b0;
      done        <= 1'b0;
      timeout_err <= 1'b0;
      seg_data    <= '0;
      tmo_cnt     <= '0;
    end else begin
      ack0      <= ack0_nxt;
      ack1      <= ack1_nxt;
      seg_start <= seg_start_nxt;
      done      <= done_nxt;
      if (tmo_set) timeout_err <= 1'b1;
      if (grant_ok) seg_data <= grant[1] ? data1 : data0;
      if (state == START) tmo_cnt <= '0;
      else if (in_wait)   tmo_cnt <= tmo_cnt + TMO_W'(1);
    end
  end

endmodule

// File: tb/tb_seg_frame_sched.sv
// Directed bench for seg_frame_sched: vector table of single/contended
// transfers plus hand-written hold-off, timeout, reset and refresh sequences.
module tb_seg_frame_sched;

  localparam int FW  = 64;
  localparam int TMO = 256;
  localparam int REF = 100;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req0, req1;
  logic [FW-1:0] data0, data1;
  logic          ack0, ack1;
  logic [FW-1:0] seg_data;
  logic          seg_start, seg_finish, busy, done, timeout_err;

  always #5 clk = ~clk;

  seg_frame_sched #(
    .FRAME_W        (FW),
    .TIMEOUT_CYCLES (TMO),
    .REFRESH_CYCLES (REF)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req0        (req0),
    .data0       (data0),
    .ack0        (ack0),
    .req1        (req1),
    .data1       (data1),
    .ack1        (ack1),
    .seg_data    (seg_data),
    .seg_start   (seg_start),
    .seg_finish  (seg_finish),
    .busy        (busy),
    .done        (done),
    .timeout_err (timeout_err)
  );

  typedef struct {
    logic          req0;
    logic          req1;
    logic [FW-1:0] data0;
    logic [FW-1:0] data1;
    int            grant;
    logic [FW-1:0] exp_data;
  } vec_t;

  vec_t vecs [8];

  int n_pass = 0, n_total = 0;
  int n_done, n_start, n_ack0, n_ack1;
  logic ser_hang = 1'b0, ser_force = 1'b0;
  int   ser_cnt  = 0;

  // Serializer model: finish drops the cycle after start, rises 65 later.
  initial begin
    seg_finish = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (!ser_force) begin
        if (ser_cnt > 0) begin
          ser_cnt = ser_cnt - 1;
          if (ser_cnt == 0 && !ser_hang) seg_finish = 1'b1;
        end else if (seg_start) begin
          seg_finish = 1'b0;
          ser_cnt    = 65;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [FW-1:0] act,
                       input logic [FW-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(negedge clk);
    if (done)      n_done++;
    if (seg_start) n_start++;
    if (ack0)      n_ack0++;
    if (ack1)      n_ack1++;
  endtask

  // Called on the ack cycle; follows the transfer through to done.
  task automatic finish_xfer(input string tag);
    logic [FW-1:0] held;
    int cyc, changes;
    held = seg_data;
    n_start = 0; n_done = 0; n_ack0 = 0; n_ack1 = 0;
    tick();
    check({tag, " seg_start"}, seg_start, 1);
    cyc = 0; changes = 0;
    while (!done && cyc < 300) begin
      tick();
      cyc++;
      if (seg_data !== held) changes++;
    end
    check({tag, " done"}, done, 1);
    check({tag, " start_pulses"}, n_start, 1);
    check({tag, " done_pulses"}, n_done, 1);
    check({tag, " acks_while_busy"}, n_ack0 + n_ack1, 0);
    check({tag, " seg_data_stable"}, changes, 0);
    check({tag, " busy_after"}, busy, 0);
  endtask

  task automatic run_vec(input int i);
    vec_t v;
    int   lat;
    string tag;
    v   = vecs[i];
    tag = $sformatf("vec%0d", i);
    req0 = v.req0; req1 = v.req1; data0 = v.data0; data1 = v.data1;
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!ack0 && !ack1 && lat < 20);
    check({tag, " ack_latency"}, lat, 1);
    check({tag, " ack0"}, ack0, (v.grant == 0) ? 1 : 0);
    check({tag, " ack1"}, ack1, (v.grant == 1) ? 1 : 0);
    check({tag, " seg_data"}, seg_data, v.exp_data);
    check({tag, " busy"}, busy, 1);
    check({tag, " done_low_at_ack"}, done, 0);
    finish_xfer(tag);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " ack0"}, ack0, 0);
    check({tag, " ack1"}, ack1, 0);
    check({tag, " seg_start"}, seg_start, 0);
    check({tag, " busy"}, busy, 0);
    check({tag, " done"}, done, 0);
    check({tag, " timeout_err"}, timeout_err, 0);
    check({tag, " seg_data"}, seg_data, 0);
  endtask

  initial begin
    logic [FW-1:0] held;
    int cyc;

    // grant follows the pointer: starts at 0, moves to the loser on each grant
    vecs[0] = '{1'b1, 1'b0, 64'h0123_4567_89AB_CDEF, 64'h0, 0, 64'h0123_4567_89AB_CDEF};
    vecs[1] = '{1'b0, 1'b1, 64'h0, 64'hFEDC_BA98_7654_3210, 1, 64'hFEDC_BA98_7654_3210};
    vecs[2] = '{1'b1, 1'b1, 64'hA0A0_0000_0000_0002, 64'hB0B0_0000_0000_0002, 0, 64'hA0A0_0000_0000_0002};
    vecs[3] = '{1'b1, 1'b1, 64'hA0A0_0000_0000_0003, 64'hB0B0_0000_0000_0003, 1, 64'hB0B0_0000_0000_0003};
    vecs[4] = '{1'b1, 1'b1, 64'hA0A0_0000_0000_0004, 64'hB0B0_0000_0000_0004, 0, 64'hA0A0_0000_0000_0004};
    vecs[5] = '{1'b1, 1'b1, 64'hA0A0_0000_0000_0005, 64'hB0B0_0000_0000_0005, 1, 64'hB0B0_0000_0000_0005};
    vecs[6] = '{1'b0, 1'b1, 64'h5555_5555_5555_5555, 64'h0, 1, 64'h0};
    vecs[7] = '{1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 0, 64'hFFFF_FFFF_FFFF_FFFF};

    rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0; data0 = '0; data1 = '0;
    n_done = 0; n_start = 0; n_ack0 = 0; n_ack1 = 0;
    repeat (3) tick();
    check_reset_outputs("reset");
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 8; i++) run_vec(i);
    req0 = 1'b0; req1 = 1'b0;
    tick();

    // Hold-off: serializer reports not-idle, request must wait.
    ser_force = 1'b1; seg_finish = 1'b0;
    req1 = 1'b1; data1 = 64'h1111_2222_3333_4444;
    n_ack0 = 0; n_ack1 = 0; n_start = 0;
    repeat (6) tick();
    check("holdoff acks", n_ack0 + n_ack1, 0);
    check("holdoff starts", n_start, 0);
    check("holdoff busy", busy, 0);
    seg_finish = 1'b1; ser_force = 1'b0;
    tick();
    check("holdoff ack1", ack1, 1);
    check("holdoff seg_data", seg_data, 64'h1111_2222_3333_4444);
    req1 = 1'b0;
    finish_xfer("holdoff");

    // Timeout: serializer never comes back after start.
    ser_hang = 1'b1;
    req0 = 1'b1; data0 = 64'hC0FF_EE00_DEAD_BEEF;
    tick();
    check("tmo ack0", ack0, 1);
    req0 = 1'b0;
    n_done = 0;
    tick();
    check("tmo seg_start", seg_start, 1);
    repeat (255) tick();
    check("tmo err_before_limit", timeout_err, 0);
    check("tmo busy_before_limit", busy, 1);
    tick();
    check("tmo err_at_limit", timeout_err, 1);
    check("tmo idle_after", busy, 0);
    check("tmo no_done", n_done, 0);
    check("tmo seg_data_kept", seg_data, 64'hC0FF_EE00_DEAD_BEEF);
    ser_hang = 1'b0; seg_finish = 1'b1;
    req1 = 1'b1; data1 = 64'h7777_8888_9999_AAAA;
    tick();
    check("post_tmo ack1", ack1, 1);
    check("post_tmo seg_data", seg_data, 64'h7777_8888_9999_AAAA);
    req1 = 1'b0;
    finish_xfer("post_tmo");
    check("post_tmo err_sticky", timeout_err, 1);

    // Reset during WAIT_DONE; pointer would favour producer 1 without it.
    req0 = 1'b1; data0 = 64'h0BAD_F00D_0000_0001;
    tick();
    check("rst_mid ack0", ack0, 1);
    req1 = 1'b1; data1 = 64'h0BAD_F00D_0000_0002;
    repeat (10) tick();
    check("rst_mid busy_pre", busy, 1);
    rst_n = 1'b0;
    tick();
    check_reset_outputs("rst_mid");
    tick();
    rst_n = 1'b1;
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (!ack0 && !ack1 && cyc < 100);
    check("rst_mid ack0_wins", ack0, 1);
    check("rst_mid ack1_loses", ack1, 0);
    check("rst_mid seg_data", seg_data, 64'h0BAD_F00D_0000_0001);
    req0 = 1'b0; req1 = 1'b0;
    finish_xfer("rst_mid");

`ifdef SEG_REFRESH_EN
    held = seg_data;
    n_start = 0; n_ack0 = 0; n_ack1 = 0;
    repeat (400) tick();
    check("refresh starts", (n_start >= 2) ? 1 : 0, 1);
    check("refresh no_acks", n_ack0 + n_ack1, 0);
    check("refresh seg_data", seg_data, held);
    cyc = 0;
    while (!done && cyc < 300) begin
      tick();
      cyc++;
    end
    check("refresh done_seen", done, 1);
    repeat (100) tick();
    req0 = 1'b1; data0 = 64'h4242_4242_4242_4242;
    tick();
    check("refresh_expiry ack0", ack0, 1);
    check("refresh_expiry seg_data", seg_data, 64'h4242_4242_4242_4242);
    req0 = 1'b0;
    finish_xfer("refresh_expiry");
`else
    held = seg_data;
    n_start = 0;
    repeat (300) tick();
    check("idle no_starts", n_start, 0);
    check("idle busy", busy, 0);
    check("idle seg_data", seg_data, held);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
